// File: rtl/note_player_pkg.sv
// Shared constants, state encoding and lookup helpers for the note playback path.
package note_player_pkg;

    localparam int unsigned OCTAVE_BITS     = 3;
    localparam int unsigned NOTE_BITS       = 3;
    localparam int unsigned LENGTH_BITS     = 3;
    localparam int unsigned NOTE_KEY_BITS   = 7;
    localparam int unsigned LENGTH_KEY_BITS = 7;

    localparam int unsigned DUR_W  = 29;
    localparam int unsigned TONE_W = 22;
    localparam int unsigned GAP_W  = 21;

    localparam logic [NOTE_BITS-1:0]   NOTE_REST  = 3'd7;
    localparam logic [LENGTH_BITS-1:0] LENGTH_MAX = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP
    } state_t;

    // Octave-0 half periods at 100 MHz; higher octaves shift right.
    function automatic logic [TONE_W-1:0] note_half(input logic [NOTE_BITS-1:0] note);
        logic [TONE_W-1:0] half;
        case (note)
            3'd0:    half = 22'd3058104;
            3'd1:    half = 22'd2724796;
            3'd2:    half = 22'd2427185;
            3'd3:    half = 22'd2290426;
            3'd4:    half = 22'd2040816;
            3'd5:    half = 22'd1818182;
            3'd6:    half = 22'd1619696;
            default: half = '0;
        endcase
        return half;
    endfunction

    function automatic logic [6:0] onehot7(input logic [2:0] idx);
        return 7'(1) << idx;
    endfunction

endpackage

// File: rtl/note_player_if.sv
// Event handshake carrying one {octave, note, length} event per transfer.
interface note_player_if;
    import note_player_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [OCTAVE_BITS-1:0] in_octave;
    logic [NOTE_BITS-1:0]   in_note;
    logic [LENGTH_BITS-1:0] in_length;

    modport master (
        output in_valid, in_octave, in_note, in_length,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_octave, in_note, in_length,
        output in_ready
    );

endinterface

// File: rtl/note_player_tone_gen.sv
// Free-running half-period divider producing the buzzer square wave; idles low when not running.
module tone_gen
    import note_player_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [TONE_W-1:0] half,
    output logic              wave
);

    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              wave_q, wave_d;

    always_comb begin
        tone_cnt_d = '0;
        wave_d     = 1'b0;
        if (run) begin
            if (tone_cnt_q == half - TONE_W'(1)) begin
                tone_cnt_d = '0;
                wave_d     = ~wave_q;
            end else begin
                tone_cnt_d = tone_cnt_q + TONE_W'(1);
                wave_d     = wave_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt_q <= '0;
            wave_q     <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            wave_q     <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/note_player.sv
// Plays one handshaken note event on the buzzer for its encoded length, then a fixed silent gap,
// echoing the event on one-hot LEDs.
module note_player
    import note_player_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 6_250_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    note_player_if.slave               in_if,
    output logic                       buzzer,
    output logic [NOTE_KEY_BITS-1:0]   note_led,
    output logic [LENGTH_KEY_BITS-1:0] length_led,
    output logic                       busy,
    output logic                       done
);

    state_t                 state_q, state_d;
    logic [DUR_W-1:0]       dur_cnt_q, dur_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [NOTE_BITS-1:0]   note_q, note_d;
    logic [OCTAVE_BITS-1:0] octave_q, octave_d;
    logic [LENGTH_BITS-1:0] len_q, len_d;
    logic [6:0]             note_led_q, note_led_d;
    logic [6:0]             length_led_q, length_led_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic [LENGTH_BITS-1:0] len_in;
    logic [DUR_W-1:0]       dur_last;
    logic [GAP_W-1:0]       gap_last;
    logic                   tone_run;
    logic [TONE_W-1:0]      tone_half;
    logic                   tone_wave;

    assign in_if.in_ready = rst_n & en & (state_q == ST_IDLE);
    assign accept         = in_if.in_valid & in_if.in_ready;
    assign len_in         = (in_if.in_length > LENGTH_MAX) ? LENGTH_MAX : in_if.in_length;
    assign dur_last       = (DUR_W'(UNIT_CYCLES) << len_q) - DUR_W'(1);
    assign gap_last       = GAP_W'(GAP_CYCLES - 1);

    always_comb begin
        state_d      = state_q;
        dur_cnt_d    = dur_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        note_d       = note_q;
        octave_d     = octave_q;
        len_d        = len_q;
        note_led_d   = note_led_q;
        length_led_d = length_led_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        if (!en) begin
            state_d      = ST_IDLE;
            dur_cnt_d    = '0;
            gap_cnt_d    = '0;
            note_led_d   = '0;
            length_led_d = '0;
            busy_d       = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d      = ST_PLAY;
                        dur_cnt_d    = '0;
                        note_d       = in_if.in_note;
                        octave_d     = in_if.in_octave;
                        len_d        = len_in;
                        note_led_d   = (in_if.in_note == NOTE_REST) ? '0 : onehot7(in_if.in_note);
                        length_led_d = onehot7(len_in);
                        busy_d       = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (dur_cnt_q == dur_last) begin
                        state_d   = ST_GAP;
                        dur_cnt_d = '0;
                        gap_cnt_d = '0;
                    end else begin
                        dur_cnt_d = dur_cnt_q + DUR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == gap_last) begin
                        state_d      = ST_IDLE;
                        gap_cnt_d    = '0;
                        note_led_d   = '0;
                        length_led_d = '0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dur_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            note_q       <= '0;
            octave_q     <= '0;
            len_q        <= '0;
            note_led_q   <= '0;
            length_led_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dur_cnt_q    <= dur_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            note_q       <= note_d;
            octave_q     <= octave_d;
            len_q        <= len_d;
            note_led_q   <= note_led_d;
            length_led_q <= length_led_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Divider clears one cycle after PLAY ends, so the wave is also masked by state.
    assign tone_run  = (state_q == ST_PLAY) && (note_q != NOTE_REST);
    assign tone_half = note_half(note_q) >> octave_q;

    tone_gen u_tone_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (tone_run),
        .half  (tone_half),
        .wave  (tone_wave)
    );

    assign buzzer     = tone_wave & (state_q == ST_PLAY);
    assign note_led   = note_led_q;
    assign length_led = length_led_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_note_player.sv
// Randomized scoreboard bench for note_player: a timing/LED/tone model derived from the event
// fields is compared every cycle, plus a long-unit instance that exercises real buzzer toggles.
module tb_note_player;
    import note_player_pkg::*;

    localparam int unsigned TB_UNIT = 8;
    localparam int unsigned TB_GAP  = 4;
    localparam int unsigned T2_UNIT = 2000;
    localparam int unsigned T2_LEN  = 4;

    typedef struct {
        bit [2:0] note;
        bit [2:0] oct;
        bit [2:0] len;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n, en, rst2_n, en2;
    logic       buzzer, busy, done, buzzer2, busy2, done2;
    logic [6:0] note_led, length_led, note_led2, length_led2;

    note_player_if if_m ();
    note_player_if if2 ();

    note_player #(.UNIT_CYCLES(TB_UNIT), .GAP_CYCLES(TB_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_if(if_m), .buzzer(buzzer),
        .note_led(note_led), .length_led(length_led), .busy(busy), .done(done)
    );

    note_player #(.UNIT_CYCLES(T2_UNIT), .GAP_CYCLES(TB_GAP)) dut2 (
        .clk(clk), .rst_n(rst2_n), .en(en2), .in_if(if2), .buzzer(buzzer2),
        .note_led(note_led2), .length_led(length_led2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int unsigned half_tbl [7] = '{3058104, 2724796, 2427185, 2290426, 2040816, 1818182, 1619696};

    ev_t exp_q [$];
    ev_t cur;
    bit  active = 1'b0;
    int  acc_cyc = 0;

    bit          act2 = 1'b0;
    bit          t2_done = 1'b0;
    int          a2 = 0;
    int unsigned half2 = 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic int unsigned dur_of(input ev_t e);
        return TB_UNIT << ((e.len == 3'd7) ? 6 : int'(e.len));
    endfunction

    function automatic int unsigned half_of(input ev_t e);
        return (e.note == 3'd7) ? 1 : (half_tbl[e.note] >> e.oct);
    endfunction

    // Scoreboard monitor: expected outputs follow from the accepted event and elapsed cycles.
    always @(negedge clk) begin : mon
        int          k;
        int unsigned dur;
        int unsigned hlf;
        bit          eb, ed, ez;
        if (!rst_n) begin
            active = 1'b0;
            chk("rst_ready",  if_m.in_ready, 0);
            chk("rst_busy",   busy, 0);
            chk("rst_buzzer", buzzer, 0);
            chk("rst_nled",   note_led, 0);
            chk("rst_lled",   length_led, 0);
            chk("rst_done",   done, 0);
        end else begin
            k   = cyc - acc_cyc;
            dur = dur_of(cur);
            hlf = half_of(cur);
            eb  = active && (k < int'(dur + TB_GAP));
            ed  = active && (k == int'(dur + TB_GAP));
            ez  = active && (k < int'(dur)) && (cur.note != 3'd7) && (((k / int'(hlf)) % 2) == 1);
            chk("busy",   busy, eb);
            chk("done",   done, ed);
            chk("buzzer", buzzer, ez);
            chk("note_led",   note_led, (eb && cur.note != 3'd7) ? (longint'(1) << cur.note) : 0);
            chk("length_led", length_led, eb ? (longint'(1) << ((cur.len == 3'd7) ? 6 : cur.len)) : 0);
            chk("in_ready", if_m.in_ready, en && !eb);
            if (active && (ed || !en)) active = 1'b0;
            if (en && !eb && if_m.in_valid) begin
                chk("accept_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur     = exp_q.pop_front();
                    acc_cyc = cyc + 1;
                    active  = 1'b1;
                end
            end
        end
    end

    // Long-unit instance: checks actual buzzer edges against 2*half periods.
    always @(negedge clk) begin : mon2
        int k;
        if (act2) begin
            k = cyc - a2;
            chk("t2_buzzer", buzzer2, (k < int'(T2_UNIT << T2_LEN)) && (((k / int'(half2)) % 2) == 1));
            chk("t2_busy",   busy2, k < int'((T2_UNIT << T2_LEN) + TB_GAP));
            chk("t2_done",   done2, k == int'((T2_UNIT << T2_LEN) + TB_GAP));
            if (k == int'((T2_UNIT << T2_LEN) + TB_GAP)) act2 = 1'b0;
        end
    end

    task automatic send(input bit [2:0] n, input bit [2:0] o, input bit [2:0] l);
        ev_t e;
        bit  got;
        e.note = n;
        e.oct  = o;
        e.len  = l;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        if_m.in_note   = n;
        if_m.in_octave = o;
        if_m.in_length = l;
        if_m.in_valid  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            got = if_m.in_ready;
        end
        chk("send_accept", got, 1);
        if (!got) void'(exp_q.pop_back());
        @(posedge clk);
        #1 if_m.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        chk("idle_timeout", idle, 1);
    endtask

    initial begin : drv
        rst_n = 1'b0;
        en    = 1'b1;
        if_m.in_valid  = 1'b0;
        if_m.in_note   = '0;
        if_m.in_octave = '0;
        if_m.in_length = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset in the middle of a long PLAY
        send(3'd5, 3'd4, 3'd6);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_buzzer", buzzer, 0);
        chk("midrst_busy",   busy, 0);
        chk("midrst_nled",   note_led, 0);
        chk("midrst_lled",   length_led, 0);
        chk("midrst_ready",  if_m.in_ready, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", if_m.in_ready, 1);

        send(3'd5, 3'd4, 3'd0);
        wait_idle();
        send(3'd0, 3'd7, 3'd6);
        wait_idle();
        send(3'd7, 3'd3, 3'd2);
        wait_idle();
        send(3'd2, 3'd4, 3'd7);
        wait_idle();

        for (int i = 0; i < 12; i++) begin
            send(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
            if ($urandom_range(1, 0) == 1) begin
                wait_idle();
                repeat ($urandom_range(3, 0)) @(posedge clk);
            end
        end
        wait_idle();

        // Second event held while the first plays
        send(3'd1, 3'd4, 3'd2);
        send(3'd6, 3'd5, 3'd1);
        wait_idle();

        // Abort with en low during PLAY
        send(3'd3, 3'd4, 3'd3);
        repeat (5) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1 en = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        send(3'd4, 3'd4, 3'd0);
        wait_idle();

        for (int i = 0; i < 40000 && !t2_done; i++) @(posedge clk);
        chk("t2_finished", t2_done, 1);
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : drv2
        bit       got2;
        bit [2:0] n2;
        rst2_n = 1'b0;
        en2    = 1'b1;
        if2.in_valid  = 1'b0;
        if2.in_note   = '0;
        if2.in_octave = '0;
        if2.in_length = '0;
        repeat (3) @(posedge clk);
        #2 rst2_n = 1'b1;
        @(posedge clk);
        #1;
        n2 = 3'(4 + $urandom_range(2, 0));
        if2.in_note   = n2;
        if2.in_octave = 3'd7;
        if2.in_length = 3'(T2_LEN);
        if2.in_valid  = 1'b1;
        got2 = 1'b0;
        for (int i = 0; i < 10 && !got2; i++) begin
            @(negedge clk);
            got2 = if2.in_ready;
        end
        chk("t2_accept", got2, 1);
        @(posedge clk);
        #1 if2.in_valid = 1'b0;
        if (got2) begin
            half2 = half_tbl[n2] >> 7;
            a2    = cyc;
            act2  = 1'b1;
            for (int i = 0; i < 40000 && act2; i++) @(posedge clk);
            chk("t2_complete", act2, 0);
        end
        t2_done = 1'b1;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
        $fatal(1);
    end

endmodule
